// File: rtl/timing_cnt.sv
// timing_cnt: up/down interval counter with start/stop FSM, four run modes,
// registered done pulse and cascade carry. Optional prescaler: TIMING_CNT_PRESCALE_EN.
module timing_cnt #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic            ud,
  input  logic            cnt_en,
  input  logic            rci,
  input  logic [SIZE-1:0] ld_val,
  input  logic [SIZE-1:0] term,
  input  logic [SIZE-1:0] resd,
`ifdef TIMING_CNT_PRESCALE_EN
  input  logic [7:0]      psc,
`endif
  output logic [SIZE-1:0] q,
  output logic            busy,
  output logic            done,
  output logic            rco
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] M_ONESHOT = 2'b00;
  localparam logic [1:0] M_RELOAD  = 2'b01;
  localparam logic [1:0] M_WRAP    = 2'b10;
  localparam logic [1:0] M_SAT     = 2'b11;

  state_e          state_q, state_d;
  logic [SIZE-1:0] q_q, q_d;
  logic            done_q, done_d;
  logic [1:0]      mode_q, mode_d;
  logic            ud_q, ud_d;
  logic            sat_q, sat_d;

  logic            clr;
  logic            qual_en;
  logic            tick;
  logic            step;
  logic [SIZE:0]   nxt;

  assign clr     = ~nReset | rst;
  assign qual_en = (state_q == S_RUN) & cnt_en & rci;
  assign step    = qual_en & tick;

`ifdef TIMING_CNT_PRESCALE_EN
  logic [7:0] psc_q, psc_d;

  assign tick = (psc_q == psc);

  // Prescaler: divides qualified enables by psc+1
  always_comb begin
    psc_d = psc_q;
    if (clr | stop | start) begin
      psc_d = 8'd0;
    end else if (qual_en) begin
      psc_d = tick ? 8'd0 : psc_q + 8'd1;
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    psc_q <= psc_d;
  end
`else
  assign tick = 1'b1;
`endif

  // Step result with carry/borrow in the top bit
  always_comb begin
    if (ud_q) begin
      nxt = {1'b0, q_q} + {{SIZE{1'b0}}, 1'b1};
    end else begin
      nxt = {1'b0, q_q} - {{SIZE{1'b0}}, 1'b1};
    end
  end

  // Control FSM and counter next-state, priority clear > stop > start > step
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    ud_d    = ud_q;
    sat_d   = sat_q;
    if (clr) begin
      state_d = S_IDLE;
      q_d     = resd;
      mode_d  = M_ONESHOT;
      ud_d    = 1'b1;
      sat_d   = 1'b0;
    end else if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_RUN;
      q_d     = ld_val;
      mode_d  = mode;
      ud_d    = ud;
      sat_d   = 1'b0;
    end else if (step) begin
      unique case (mode_q)
        M_ONESHOT: begin
          q_d = nxt[SIZE-1:0];
          if (nxt[SIZE-1:0] == term) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        M_RELOAD: begin
          if (nxt[SIZE-1:0] == term) begin
            q_d    = ld_val;
            done_d = 1'b1;
          end else begin
            q_d = nxt[SIZE-1:0];
          end
        end
        M_WRAP: begin
          q_d    = nxt[SIZE-1:0];
          done_d = nxt[SIZE];
        end
        M_SAT: begin
          if (nxt[SIZE]) begin
            done_d = ~sat_q;
            sat_d  = 1'b1;
          end else begin
            q_d = nxt[SIZE-1:0];
          end
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    state_q <= state_d;
    q_q     <= q_d;
    done_q  <= done_d;
    mode_q  <= mode_d;
    ud_q    <= ud_d;
    sat_q   <= sat_d;
  end

  assign q    = q_q;
  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign rco  = step & (mode_q == M_WRAP) & nxt[SIZE];

endmodule

// File: doc/timing_cnt.md
# timing_cnt

Parametrised up/down timing counter: the successor to the team's general-purpose up/down counter. It adds a start/stop control FSM, a programmable terminal value, four run modes (one-shot, auto-reload, wrap, saturate), a registered `done` pulse and a busy flag. It sits inside the ATA host controllers' PIO/DMA timing engines, and one instance times one interval (t1, t2, teoc). `rci`/`rco` let instances cascade.

## Interface
- `SIZE`, 8, counter width in bits.
- `clk` in 1: master clock; all state changes on its rising edge.
- `nReset` in 1: synchronous, active-low reset.
- `rst` in 1: synchronous, active-high clear; same effect as `nReset`.
- `start` in 1: load `ld_val`, latch `mode`/`ud`, enter RUN.
- `stop` in 1: abort; enter IDLE, `q` holds.
- `mode` in 2: 00 ONESHOT, 01 RELOAD, 10 WRAP, 11 SAT.
- `ud` in 1: 1 = count up, 0 = count down.
- `cnt_en` in 1: count enable.
- `rci` in 1: carry in; a step needs `cnt_en & rci`.
- `ld_val` in SIZE: start/reload value.
- `term` in SIZE: terminal value, used in ONESHOT/RELOAD; sampled live.
- `resd` in SIZE: value of `q` during/after reset.
- `q` out SIZE: current count.
- `busy` out 1: high in RUN.
- `done` out 1: registered one-cycle event pulse.
- `rco` out 1: combinational carry/borrow out, WRAP mode only.

## Operation
- Control priority, highest first: `nReset`=0, then `rst`=1, then `stop`, then `start`, then step.
- Reset or clear sets: state IDLE, `q`=`resd`, `busy`=0, `done`=0, `mode_r`=00, `ud_r`=1.
- FSM states are IDLE and RUN.
  - IDLE→RUN on `start`.
  - RUN→IDLE on `stop`, or on the terminal event in ONESHOT.
  - `start` while in RUN restarts the count: reload `ld_val`, re-latch `mode`/`ud`, no `done`.
  - `start` and `stop` in the same cycle: `stop` wins.
- `mode_r`/`ud_r` are latched only on `start`. Changing `mode`/`ud` mid-run has no effect.
- Step: state RUN & `cnt_en` & `rci` (and prescaler tick when configured).
  - `nxt` = `q`+1 if `ud_r`, else `q`−1, computed in SIZE+1 bits.
  - No step occurs in IDLE; `q` holds.
- Behaviour on a step, per mode:
  - ONESHOT: `q`←`nxt`. If `nxt[SIZE-1:0]`==`term`, then `done` is set and state goes to IDLE.
  - RELOAD: if `nxt`==`term`, `q`←`ld_val` and `done` is set; otherwise `q`←`nxt`. Period = |`ld_val`−`term`| steps, and `q` never shows `term`. If `ld_val`==`term`, the first step runs the full modulo-2^SIZE lap.
  - WRAP: `term` is ignored. `q`←`nxt[SIZE-1:0]`, wrapping. `done` is set on the wrap step (all-ones→0 counting up, 0→all-ones counting down).
  - SAT: `term` is ignored. `q` clamps at all-ones (up) or 0 (down). `done` is set on the first step that would overflow; later clamped steps do not set it. A new `start` re-arms it. Stays in RUN.
- `rco` = step & `mode_r`==WRAP & `nxt[SIZE]`. It is 0 in every other mode and in IDLE.
- `busy` = (state==RUN), registered.

## Timing
- `start` at edge N gives `q`=`ld_val` and `busy`=1 from cycle N+1. The first possible step is edge N+1.
- `done` is asserted for exactly one cycle, the same cycle `q` first shows the post-step value. It is never high two cycles in a row unless a second terminal event occurs.
- Example, ONESHOT, `ld_val`=5, `term`=0, down, `cnt_en`=`rci`=1: `q` reads 5,4,3,2,1,0; `done`=1 and `busy`=0 together on the cycle `q`=0.
- `stop` or `rst` in the same cycle as a terminal step: the control action wins and `done` stays 0.
- `rco` is combinational from the registered state and the inputs, with zero latency.

## Configuration
- `TIMING_CNT_PRESCALE_EN` defined:
  - Adds input `psc` [7:0] and an internal 8-bit prescaler.
  - A step requires `cnt_en & rci` and prescaler==`psc`. The prescaler then returns to 0; otherwise it increments on each qualified enable.
  - The prescaler clears on reset, `rst`, `start` and `stop`.
  - `psc`=0 behaves identically to the unconfigured block.
- Not defined: no `psc` port and no prescaler; every qualified enable is a step.

## Test plan
- Reset: hold `nReset`=0 for 2 clk with `resd`=0xA5 → `q`=0xA5, `busy`=0, `done`=0. Releasing it, with no `start`, leaves `q` unchanged.
- ONESHOT up: `ld_val`=3, `term`=7, continuous enable → `q` reads 3,4,5,6,7; `done` pulses once at `q`=7 with `busy` falling in that cycle. Further enables leave `q`=7.
- RELOAD down: `ld_val`=4, `term`=0, SIZE=8 → `q` reads 4,3,2,1,4,3…; `done` pulses every 4 steps; `q` never reads 0.
- WRAP up: `start` with `ld_val`=0xFE → `rco`=1 during the cycle `q`=0xFF with enable; next `q`=0x00 with `done`=1.
- SAT down: `ld_val`=1 → `q` reads 1,0,0,0; `done` pulses once; `busy` stays 1 until `stop`.
- Corner cases:
  - `start`+`stop` together in RUN → IDLE, `q` held.
  - A mid-run `mode` change is ignored.
  - `rst` on the terminal step → `q`=`resd`, no `done`.
  - With the macro: `psc`=2 → one step per 3 enables.
